// File: rtl/icache_if.sv
// Fetch and refill handshake bundle between fetcher, icache and memory controller.
// slave = cache side, master = fetcher/memory side.
interface icache_if;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_ins;
  logic        fetch_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;

  modport slave (
    input  fetch_valid, fetch_pc, mem_ready, mem_data,
    output fetch_ins, fetch_ready, mem_req, mem_addr
  );
  modport master (
    output fetch_valid, fetch_pc, mem_ready, mem_data,
    input  fetch_ins, fetch_ready, mem_req, mem_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped single-word-per-line instruction cache, IDLE/REFILL/RESP FSM, registered outputs.
// Optional hit/miss counters when ICACHE_PERF_EN is defined.
module icache #(
  parameter int IDX_W = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
`ifdef ICACHE_PERF_EN
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
`endif
  icache_if.slave     bus
);
  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESP} state_t;

  state_t             r_state, w_state_nxt;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [31:0]        r_data [LINES];
  logic               r_discard, r_fetch_ready, r_mem_req;
  logic [31:0]        r_fetch_ins, r_mem_addr;

  logic [IDX_W-1:0]   w_idx, w_rf_idx;
  logic [TAG_W-1:0]   w_tag, w_rf_tag;
  logic               w_hit, w_accept;
  logic               w_discard_nxt, w_fetch_ready_nxt, w_mem_req_nxt, w_line_we;
  logic [31:0]        w_fetch_ins_nxt, w_mem_addr_nxt;

  assign w_idx    = bus.fetch_pc[IDX_W+1:2];
  assign w_tag    = bus.fetch_pc[31:IDX_W+2];
  assign w_rf_idx = r_mem_addr[IDX_W+1:2];
  assign w_rf_tag = r_mem_addr[31:IDX_W+2];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_accept = (r_state == S_IDLE) && bus.fetch_valid && !clear_in;

  // State register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     r_state <= S_IDLE;
    else if (rdy_in) r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = w_hit ? S_RESP : S_REFILL;
      S_REFILL: if (bus.mem_ready) w_state_nxt = (r_discard || clear_in) ? S_IDLE : S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and line write strobe
  always_comb begin
    w_fetch_ready_nxt = 1'b0;
    w_fetch_ins_nxt   = r_fetch_ins;
    w_mem_req_nxt     = r_mem_req;
    w_mem_addr_nxt    = r_mem_addr;
    w_discard_nxt     = r_discard;
    w_line_we         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_hit) begin
          w_fetch_ready_nxt = 1'b1;
          w_fetch_ins_nxt   = r_data[w_idx];
        end else if (w_accept) begin
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = bus.fetch_pc & ~32'h3;
        end
      end
      S_REFILL: begin
        if (bus.mem_ready) begin
          // Line is always written; a flushed fetch just suppresses the response.
          w_line_we     = 1'b1;
          w_mem_req_nxt = 1'b0;
          w_discard_nxt = 1'b0;
          if (!(r_discard || clear_in)) begin
            w_fetch_ready_nxt = 1'b1;
            w_fetch_ins_nxt   = bus.mem_data;
          end
        end else if (clear_in) begin
          w_discard_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_valid       <= '0;
      r_discard     <= 1'b0;
      r_fetch_ready <= 1'b0;
      r_fetch_ins   <= '0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
    end else if (rdy_in) begin
      if (w_line_we) r_valid[w_rf_idx] <= 1'b1;
      r_discard     <= w_discard_nxt;
      r_fetch_ready <= w_fetch_ready_nxt;
      r_fetch_ins   <= w_fetch_ins_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
    end
  end

  // Tag/data arrays carry no reset; the valid bits gate them.
  always_ff @(posedge clk_in) begin
    if (rdy_in && w_line_we) begin
      r_tag[w_rf_idx]  <= w_rf_tag;
      r_data[w_rf_idx] <= bus.mem_data;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (rdy_in && w_accept) begin
      if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      else       r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end
  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

  assign bus.fetch_ready = r_fetch_ready;
  assign bus.fetch_ins   = r_fetch_ins;
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_addr    = r_mem_addr;
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hit, alias, flush during refill, stalls, async reset.
module tb_icache;
  logic clk_in, rst_in, rdy_in, clear_in;
  icache_if bus();
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  icache #(.IDX_W(6)) dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rdy_in  (rdy_in),
    .clear_in(clear_in),
`ifdef ICACHE_PERF_EN
    .hit_cnt (hit_cnt),
    .miss_cnt(miss_cnt),
`endif
    .bus     (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_fail = 0;
  int n_pulse = 0;
  int p0;

  // Responses the fetcher actually consumes (ready seen while not stalled)
  always @(posedge clk_in) if (rdy_in && bus.fetch_ready) n_pulse <= n_pulse + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  // Miss then refill; memory answers two cycles after acceptance (after an optional stall).
  task automatic fetch_miss(input logic [31:0] pc, input logic [31:0] word, input int stall);
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = pc;
    tick;
    chk("miss_req", {31'd0, bus.mem_req}, 32'd1);
    chk("miss_addr", bus.mem_addr, pc & ~32'h3);
    chk("miss_nordy", {31'd0, bus.fetch_ready}, 32'd0);
    rdy_in = 1'b0;
    for (int i = 0; i < stall; i++) begin
      tick;
      chk("stall_req", {31'd0, bus.mem_req}, 32'd1);
      chk("stall_addr", bus.mem_addr, pc & ~32'h3);
    end
    rdy_in = 1'b1;
    tick;
    chk("refill_hold", {31'd0, bus.mem_req}, 32'd1);
    bus.mem_ready = 1'b1;
    bus.mem_data  = word;
    tick;
    bus.mem_ready = 1'b0;
    chk("refill_rdy", {31'd0, bus.fetch_ready}, 32'd1);
    chk("refill_ins", bus.fetch_ins, word);
    chk("refill_reqlo", {31'd0, bus.mem_req}, 32'd0);
    tick;  // fetcher still holds valid during RESP: must not re-fetch
    bus.fetch_valid = 1'b0;
    chk("resp_single", {31'd0, bus.fetch_ready}, 32'd0);
    tick;
    chk("no_double", {31'd0, bus.fetch_ready}, 32'd0);
  endtask

  task automatic fetch_hit(input logic [31:0] pc, input logic [31:0] word);
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = pc;
    tick;
    chk("hit_rdy", {31'd0, bus.fetch_ready}, 32'd1);
    chk("hit_ins", bus.fetch_ins, word);
    chk("hit_noreq", {31'd0, bus.mem_req}, 32'd0);
    tick;
    bus.fetch_valid = 1'b0;
    chk("hit_single", {31'd0, bus.fetch_ready}, 32'd0);
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
    bus.fetch_valid = 1'b0; bus.fetch_pc = '0;
    bus.mem_ready = 1'b0; bus.mem_data = '0;
    #12;
    chk("rst_rdy", {31'd0, bus.fetch_ready}, 32'd0);
    chk("rst_ins", bus.fetch_ins, 32'd0);
    chk("rst_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    rst_in = 1'b1;
    tick;

    fetch_miss(32'h0000_0000, 32'h0000_0013, 0);
    fetch_hit(32'h0000_0000, 32'h0000_0013);
`ifdef ICACHE_PERF_EN
    chk("perf_hit", hit_cnt, 32'd1);
    chk("perf_miss", miss_cnt, 32'd1);
`endif

    // Back-to-back hits with valid held: one response every two cycles
    bus.fetch_valid = 1'b1; bus.fetch_pc = 32'h0000_0003;
    tick; chk("b2b_r0", {31'd0, bus.fetch_ready}, 32'd1);
    tick; chk("b2b_gap", {31'd0, bus.fetch_ready}, 32'd0);
    tick; chk("b2b_r1", {31'd0, bus.fetch_ready}, 32'd1);
    chk("b2b_ins", bus.fetch_ins, 32'h0000_0013);
    tick; bus.fetch_valid = 1'b0;
    chk("b2b_end", {31'd0, bus.fetch_ready}, 32'd0);

    // Alias on index 0 evicts, then the original misses again
    fetch_miss(32'h0000_0100, 32'hAAAA_0100, 0);
    fetch_miss(32'h0000_0000, 32'h0000_0013, 0);

    // Flush during refill: line still written, no response
    bus.fetch_valid = 1'b1; bus.fetch_pc = 32'h0000_0004;
    tick;
    chk("clr_req", {31'd0, bus.mem_req}, 32'd1);
    clear_in = 1'b1; bus.fetch_valid = 1'b0;
    tick;
    clear_in = 1'b0;
    chk("clr_hold", {31'd0, bus.mem_req}, 32'd1);
    bus.mem_ready = 1'b1; bus.mem_data = 32'hDEAD_BEEF;
    tick;
    bus.mem_ready = 1'b0;
    chk("clr_nordy", {31'd0, bus.fetch_ready}, 32'd0);
    chk("clr_reqlo", {31'd0, bus.mem_req}, 32'd0);
    tick;
    chk("clr_nordy2", {31'd0, bus.fetch_ready}, 32'd0);
    fetch_hit(32'h0000_0004, 32'hDEAD_BEEF);

    // Clear together with a request in IDLE: not accepted
    bus.fetch_valid = 1'b1; bus.fetch_pc = 32'h0000_0000; clear_in = 1'b1;
    tick;
    clear_in = 1'b0; bus.fetch_valid = 1'b0;
    chk("clr_idle_rdy", {31'd0, bus.fetch_ready}, 32'd0);
    chk("clr_idle_req", {31'd0, bus.mem_req}, 32'd0);

    // Stall during RESP: ready held, consumed once
    p0 = n_pulse;
    bus.fetch_valid = 1'b1; bus.fetch_pc = 32'h0000_0000;
    tick;
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("stall_rdy", {31'd0, bus.fetch_ready}, 32'd1);
    end
    rdy_in = 1'b1;
    tick;
    bus.fetch_valid = 1'b0;
    chk("stall_drop", {31'd0, bus.fetch_ready}, 32'd0);
    tick;
    chk("stall_pulses", n_pulse - p0, 32'd1);

    // Stall during REFILL keeps request and address
    fetch_miss(32'h0000_0008, 32'h0080_0093, 3);

    // Async reset mid-refill
    bus.fetch_valid = 1'b1; bus.fetch_pc = 32'h0000_000C;
    tick;
    chk("ar_req", {31'd0, bus.mem_req}, 32'd1);
    #2 rst_in = 1'b0; bus.fetch_valid = 1'b0;
    #1 chk("ar_reqlo", {31'd0, bus.mem_req}, 32'd0);
    #1 rst_in = 1'b1; bus.mem_ready = 1'b1; bus.mem_data = 32'h1111_1111;
    tick;
    bus.mem_ready = 1'b0;
    chk("ar_ignored", {31'd0, bus.fetch_ready}, 32'd0);
    chk("ar_noreq", {31'd0, bus.mem_req}, 32'd0);
    fetch_miss(32'h0000_0000, 32'h0000_0013, 0);
    fetch_miss(32'h0000_0004, 32'hDEAD_BEEF, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter IDX_W, default 6, log2 of line count (64 direct-mapped lines, one 32-bit instruction per line).
REQ-002 clk_in  input  1  system clock; all state updates on rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-low.
REQ-004 rdy_in  input  1  global ready; low freezes all state and outputs.
REQ-005 clear_in  input  1  pipeline flush from ROB; abandon current fetch.
REQ-006 fetch_valid  input  1  fetcher request; held high with fetch_pc stable until fetch_ready.
REQ-007 fetch_pc  input  32  fetch address; bits [1:0] ignored.
REQ-008 fetch_ins  output  32  instruction word for the accepted request.
REQ-009 fetch_ready  output  1  one-cycle pulse; fetch_ins valid.
REQ-010 mem_req  output  1  refill request to memory controller; held until mem_ready.
REQ-011 mem_addr  output  32  refill word address, {fetch_pc[31:2],2'b00}.
REQ-012 mem_ready  input  1  one-cycle pulse; mem_data valid.
REQ-013 mem_data  input  32  refill word.

Function
REQ-014 Address split: index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; per-line valid bit, tag, data.
REQ-015 FSM states IDLE, REFILL, RESP; all outputs registered.
REQ-016 IDLE: request accepted at edge with fetch_valid=1, clear_in=0; hit -> RESP with fetch_ins=line data; miss -> REFILL with mem_req=1, mem_addr latched.
REQ-017 Hit latency: fetch_ready high exactly one cycle after acceptance edge.
REQ-018 REFILL: mem_req/mem_addr stable until mem_ready; at that edge line written (valid=1, tag, data), fetch_ins=mem_data, go RESP, mem_req=0.
REQ-019 RESP: fetch_ready=1 for exactly one cycle, then IDLE; no request accepted in RESP (no double fetch while fetch_valid still high).
REQ-020 Back-to-back hits: one instruction per two cycles.
REQ-021 clear_in in IDLE or RESP: next state IDLE, fetch_ready=0 next cycle; fetcher ignores fetch_ready during clear cycle.
REQ-022 clear_in in REFILL: set discard flag; refill continues until mem_ready, line written, then IDLE with no fetch_ready pulse; flag cleared.
REQ-023 clear_in and fetch_valid same cycle in IDLE: request not accepted.
REQ-024 rdy_in=0: no state, array, counter or output register change; mem_req held; mem_ready pulse during rdy_in=0 not expected (controller shares rdy_in).
REQ-025 Index aliasing: refill overwrites line regardless of prior valid/tag.

Reset
REQ-026 rst_in=0 asynchronously: state IDLE, all valid bits 0, discard 0, fetch_ready 0, fetch_ins 0, mem_req 0, mem_addr 0; data/tag arrays not required to clear.
REQ-027 Reset mid-REFILL: mem_req drops immediately; in-flight response ignored.

Configuration
REQ-028 Macro ICACHE_PERF_EN defined: add outputs hit_cnt and miss_cnt (32-bit each, reset 0, increment on accepted hit/miss, wrap at 2^32, frozen when rdy_in=0).
REQ-029 ICACHE_PERF_EN undefined: counter ports and logic absent; all other behaviour identical.

Verification
REQ-030 Cold miss: reset, fetch_pc=0x0000_0000 -> mem_req, mem_addr=0x0; mem_ready with 0x0000_0013 two cycles later -> fetch_ready next cycle, fetch_ins=0x00000013.
REQ-031 Hit: re-request 0x0 -> fetch_ready one cycle after acceptance, mem_req stays 0, hit_cnt=1 (perf build).
REQ-032 Alias: fetch 0x100 (same index 0, IDX_W=6) -> miss, refill; then 0x0 -> miss again.
REQ-033 Clear in REFILL: request 0x4, assert clear_in one cycle, mem_ready with 0xDEADBEEF -> no fetch_ready; later fetch 0x4 hits with 0xDEADBEEF.
REQ-034 Stall: rdy_in=0 for 5 cycles during RESP -> fetch_ready remains high through stall, single pulse counted after rdy_in=1.
REQ-035 Async reset mid-REFILL -> mem_req=0 before next clock edge; all prior lines miss afterward.
